// File: rtl/y86_imem_loader.sv
// Y86-64 instruction loader: takes one decoded instruction per handshake and
// writes its encoded bytes, one per cycle, into consecutive instruction
// memory addresses using the byte layout the fetch stage decodes.
module y86_imem_loader #(
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter int          MEM_SIZE  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_icode,
  input  logic [3:0]  in_ifun,
  input  logic [3:0]  in_rA,
  input  logic [3:0]  in_rB,
  input  logic [63:0] in_valC,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic [15:0] instr_count,
  output logic        halt_written,
  output logic        inv_err,
  output logic        ovf_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [64:0] MEM_LIMIT = 65'(MEM_SIZE);

  state_t      state_q, state_d;
  logic [63:0] wr_ptr_q, wr_ptr_d;
  logic [79:0] shreg_q, shreg_d;
  logic [3:0]  rem_q, rem_d;
  logic        is_halt_q, is_halt_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic        halt_written_q, halt_written_d;
  logic        inv_err_q, inv_err_d;
  logic        ovf_err_q, ovf_err_d;

  logic        icode_ok;
  logic [3:0]  len;
  logic [79:0] image;
  logic [64:0] end_addr;

  // Decode instruction length and build the left-aligned byte image.
  always_comb begin
    icode_ok = 1'b1;
    len      = 4'd1;
    image    = {in_icode, in_ifun, 72'd0};
    case (in_icode)
      4'h0, 4'h1, 4'h9: begin
        len   = 4'd1;
        image = {in_icode, in_ifun, 72'd0};
      end
      4'h2, 4'h6, 4'hA, 4'hB: begin
        len   = 4'd2;
        image = {in_icode, in_ifun, in_rA, in_rB, 64'd0};
      end
      4'h7, 4'h8: begin
        len   = 4'd9;
        image = {in_icode, in_ifun, in_valC, 8'd0};
      end
      4'h3, 4'h4, 4'h5: begin
        len   = 4'd10;
        image = {in_icode, in_ifun, in_rA, in_rB, in_valC};
      end
      default: begin
        icode_ok = 1'b0;
        len      = 4'd1;
        image    = 80'd0;
      end
    endcase
    end_addr = {1'b0, wr_ptr_q} + 65'(len);
  end

  // Next-state logic: accept in IDLE, stream bytes in SEND, lock up in HALTED.
  // Byte 0 is registered on the accepting edge so it appears one cycle later;
  // rem_q counts the bytes still to be issued after the one on the bus.
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    shreg_d        = shreg_q;
    rem_d          = rem_q;
    is_halt_d      = is_halt_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    instr_count_d  = instr_count_q;
    halt_written_d = halt_written_q;
    inv_err_d      = inv_err_q;
    ovf_err_d      = ovf_err_q;
    in_ready       = (state_q == IDLE) && rst_n;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (!icode_ok) begin
            inv_err_d = 1'b1;
            state_d   = HALTED;
          end else if (end_addr > MEM_LIMIT) begin
            ovf_err_d = 1'b1;
            state_d   = HALTED;
          end else begin
            state_d     = SEND;
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_ptr_q;
            mem_wdata_d = image[79:72];
            shreg_d     = {image[71:0], 8'd0};
            wr_ptr_d    = wr_ptr_q + 64'd1;
            rem_d       = len - 4'd1;
            is_halt_d   = (in_icode == 4'h0);
          end
        end
      end
      SEND: begin
        if (rem_q != 4'd0) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_ptr_q;
          mem_wdata_d = shreg_q[79:72];
          shreg_d     = {shreg_q[71:0], 8'd0};
          wr_ptr_d    = wr_ptr_q + 64'd1;
          rem_d       = rem_q - 4'd1;
        end else begin
          state_d = IDLE;
          if (instr_count_q != 16'hFFFF) begin
            instr_count_d = instr_count_q + 16'd1;
          end
          if (is_halt_q) begin
            halt_written_d = 1'b1;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      wr_ptr_q       <= BASE_ADDR;
      shreg_q        <= 80'd0;
      rem_q          <= 4'd0;
      is_halt_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= 64'd0;
      mem_wdata_q    <= 8'd0;
      instr_count_q  <= 16'd0;
      halt_written_q <= 1'b0;
      inv_err_q      <= 1'b0;
      ovf_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      shreg_q        <= shreg_d;
      rem_q          <= rem_d;
      is_halt_q      <= is_halt_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      instr_count_q  <= instr_count_d;
      halt_written_q <= halt_written_d;
      inv_err_q      <= inv_err_d;
      ovf_err_q      <= ovf_err_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = (state_q == SEND);
  assign instr_count  = instr_count_q;
  assign halt_written = halt_written_q;
  assign inv_err      = inv_err_q;
  assign ovf_err      = ovf_err_q;

endmodule

// File: tb/tb_y86_imem_loader.sv
// Directed bench for y86_imem_loader: a full-size instance (a) and a
// 12-byte instance (b) share clock, reset and instruction fields.
module tb_y86_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_a = 1'b0;
  logic        valid_b = 1'b0;
  logic [3:0]  in_icode = 4'h0;
  logic [3:0]  in_ifun = 4'h0;
  logic [3:0]  in_rA = 4'h0;
  logic [3:0]  in_rB = 4'h0;
  logic [63:0] in_valC = 64'd0;

  logic        ready_a, we_a, busy_a, halt_a, inv_a, ovf_a;
  logic [63:0] addr_a;
  logic [7:0]  wdata_a;
  logic [15:0] count_a;
  logic        ready_b, we_b, busy_b, halt_b, inv_b, ovf_b;
  logic [63:0] addr_b;
  logic [7:0]  wdata_b;
  logic [15:0] count_b;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem_a [0:1023];
  logic [7:0] mem_b [0:15];
  int         wcyc_a [0:1023];
  int         cyc = 0;
  int         we_count_a = 0;
  int         we_count_b = 0;
  int         ready_during_we = 0;
  int         wrote_past_b = 0;

  y86_imem_loader #(.BASE_ADDR(64'd0), .MEM_SIZE(1024)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_a), .in_ready(ready_a),
    .in_icode(in_icode), .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB),
    .in_valC(in_valC), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .busy(busy_a), .instr_count(count_a), .halt_written(halt_a),
    .inv_err(inv_a), .ovf_err(ovf_a)
  );

  y86_imem_loader #(.BASE_ADDR(64'd0), .MEM_SIZE(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_b), .in_ready(ready_b),
    .in_icode(in_icode), .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB),
    .in_valC(in_valC), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .busy(busy_b), .instr_count(count_b), .halt_written(halt_b),
    .inv_err(inv_b), .ovf_err(ovf_b)
  );

  always #5 clk = ~clk;

  // Memory model: capture every write strobe half a cycle after the edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (we_a) begin
      mem_a[addr_a[9:0]] = wdata_a;
      wcyc_a[addr_a[9:0]] = cyc;
      we_count_a = we_count_a + 1;
      if (ready_a) ready_during_we = ready_during_we + 1;
    end
    if (we_b) begin
      if (addr_b >= 64'd12) wrote_past_b = wrote_past_b + 1;
      mem_b[addr_b[3:0]] = wdata_b;
      we_count_b = we_count_b + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [79:0] observed,
                             input logic [79:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 8'h00;
      wcyc_a[i] = 0;
    end
    for (int i = 0; i < 16; i++) mem_b[i] = 8'h00;
    we_count_a = 0;
    we_count_b = 0;
    ready_during_we = 0;
    wrote_past_b = 0;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clearModel();
  endtask

  // Offer one instruction; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input bit to_b, input logic [3:0] icode,
                               input logic [3:0] ifun, input logic [3:0] ra,
                               input logic [3:0] rb, input logic [63:0] valc);
    bit accepted;
    accepted = 1'b0;
    in_icode = icode;
    in_ifun  = ifun;
    in_rA    = ra;
    in_rB    = rb;
    in_valC  = valc;
    if (to_b) valid_b = 1'b1;
    else      valid_a = 1'b1;
    for (int i = 0; i < 64 && !accepted; i++) begin
      if (to_b ? ready_b : ready_a) begin
        @(posedge clk);
        accepted = 1'b1;
      end
      @(negedge clk);
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    checkOutput("accept", 80'(accepted), 80'd1);
  endtask

  task automatic waitIdle(input bit to_b);
    for (int i = 0; i < 40 && (to_b ? busy_b : busy_a); i++) @(negedge clk);
    @(negedge clk);
    checkOutput("idle_timeout", 80'(to_b ? busy_b : busy_a), 80'd0);
  endtask

  function automatic logic [79:0] imageA(input int first, input int n);
    logic [79:0] r;
    r = 80'd0;
    for (int i = 0; i < n; i++) r = {r[71:0], mem_a[first + i]};
    return r;
  endfunction

  initial begin
    int ready_seen;
    clearModel();

    // Reset values while rst_n is held low
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 80'(ready_a), 80'd0);
    checkOutput("rst_we", 80'(we_a), 80'd0);
    checkOutput("rst_addr", 80'(addr_a), 80'd0);
    checkOutput("rst_wdata", 80'(wdata_a), 80'd0);
    checkOutput("rst_busy", 80'(busy_a), 80'd0);
    checkOutput("rst_count", 80'(count_a), 80'd0);
    checkOutput("rst_flags", 80'({halt_a, inv_a, ovf_a}), 80'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst", 80'(ready_a), 80'd1);

    // irmovq $0x10, %rdx
    applyStimulus(1'b0, 4'h3, 4'h0, 4'hF, 4'h2, 64'h10);
    checkOutput("irmovq_busy", 80'(busy_a), 80'd1);
    waitIdle(1'b0);
    checkOutput("irmovq_bytes", imageA(0, 10), 80'h30F2_0000_0000_0000_0010);
    checkOutput("irmovq_we_cycles", 80'(we_count_a), 80'd10);
    checkOutput("irmovq_ready_low", 80'(ready_during_we), 80'd0);
    checkOutput("irmovq_count", 80'(count_a), 80'd1);

    // nop then halt back-to-back
    resetDut();
    applyStimulus(1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 64'd0);
    waitIdle(1'b0);
    checkOutput("nop_halt_bytes", imageA(0, 2), 80'h1000);
    checkOutput("nop_halt_bubble", 80'(wcyc_a[1] - wcyc_a[0]), 80'd2);
    checkOutput("halt_written", 80'(halt_a), 80'd1);
    checkOutput("nop_halt_count", 80'(count_a), 80'd2);

    // jXX then OPq
    resetDut();
    applyStimulus(1'b0, 4'h7, 4'h3, 4'h5, 4'h5, 64'h40);
    applyStimulus(1'b0, 4'h6, 4'h1, 4'h0, 4'h3, 64'hDEAD);
    waitIdle(1'b0);
    checkOutput("jxx_bytes", imageA(0, 9), 80'h73_0000_0000_0000_0040);
    checkOutput("opq_bytes", imageA(9, 2), 80'h6103);
    checkOutput("jxx_opq_count", 80'(count_a), 80'd2);

    // Invalid icode locks the loader up
    resetDut();
    applyStimulus(1'b0, 4'hC, 4'h0, 4'h1, 4'h2, 64'd5);
    checkOutput("inv_err", 80'(inv_a), 80'd1);
    valid_a = 1'b1;
    in_icode = 4'h1;
    ready_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready_a) ready_seen++;
    end
    valid_a = 1'b0;
    checkOutput("inv_ready_low", 80'(ready_seen), 80'd0);
    checkOutput("inv_no_writes", 80'(we_count_a), 80'd0);
    checkOutput("inv_count", 80'(count_a), 80'd0);
    checkOutput("inv_no_ovf", 80'(ovf_a), 80'd0);

    // Reset while byte index 3 of an irmovq is on the bus
    resetDut();
    applyStimulus(1'b0, 4'h3, 4'h0, 4'hF, 4'h2, 64'h1122_3344_5566_7788);
    repeat (3) @(negedge clk);
    checkOutput("mid_addr", 80'(addr_a), 80'd3);
    checkOutput("mid_we", 80'(we_a), 80'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_we", 80'(we_a), 80'd0);
    checkOutput("abort_busy", 80'(busy_a), 80'd0);
    checkOutput("abort_writes", 80'(we_count_a), 80'd4);
    checkOutput("abort_partial", 80'(mem_a[3]), 80'h22);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_ready", 80'(ready_a), 80'd1);
    applyStimulus(1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    waitIdle(1'b0);
    checkOutput("abort_nop_byte", 80'(mem_a[0]), 80'h10);
    checkOutput("abort_count", 80'(count_a), 80'd1);

    // 12-byte memory: irmovq + OPq fill it, the nop overflows
    resetDut();
    applyStimulus(1'b1, 4'h3, 4'h0, 4'hF, 4'h1, 64'h0102_0304_0506_0708);
    waitIdle(1'b1);
    applyStimulus(1'b1, 4'h6, 4'h0, 4'h1, 4'h2, 64'd0);
    waitIdle(1'b1);
    checkOutput("fill_ovf_low", 80'(ovf_b), 80'd0);
    applyStimulus(1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("ovf_err", 80'(ovf_b), 80'd1);
    checkOutput("ovf_count", 80'(count_b), 80'd2);
    checkOutput("ovf_writes", 80'(we_count_b), 80'd12);
    checkOutput("ovf_no_addr12", 80'(wrote_past_b), 80'd0);
    checkOutput("ovf_opq_bytes", 80'({mem_b[10], mem_b[11]}), 80'h6012);
    checkOutput("ovf_ready_low", 80'(ready_b), 80'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
